// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// data width, access-type codes, FSM state encoding and the memory command payload.
package mem_access_ctrl_pkg;

    localparam int unsigned REG_LEN = 32;
    localparam int unsigned TYPE_W  = 3;
    localparam int unsigned BE_W    = 4;

    // Access-type codes (funct3 encoding used by the load/store decode)
    localparam logic [TYPE_W-1:0] LSU_SB  = 3'b000;
    localparam logic [TYPE_W-1:0] LSU_SH  = 3'b001;
    localparam logic [TYPE_W-1:0] LSU_SW  = 3'b010;
    localparam logic [TYPE_W-1:0] LSU_SBU = 3'b100;
    localparam logic [TYPE_W-1:0] LSU_SHU = 3'b101;

    typedef enum logic [1:0] {
        MAC_IDLE   = 2'd0,
        MAC_ACCESS = 2'd1,
        MAC_RESP   = 2'd2
    } mac_state_e;

    // Bus fields captured on an accepted request and held for the whole access
    typedef struct packed {
        logic               we;
        logic [REG_LEN-1:0] addr;
        logic [REG_LEN-1:0] wdata;
        logic [BE_W-1:0]    be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane aligner: maps access type + low address bits + right-justified
// store data onto word byte enables and lane-replicated write data, and flags
// misaligned or unknown access types.
//   we_i        1 = store, 0 = load (loads get zero write data)
//   type_i      access-type code
//   addr_i      byte offset within the word
//   wdata_i     right-justified store data
//   be_c_o      byte enables, bit i = lane i
//   wdata_c_o   lane-replicated write data
//   illegal_c_o misaligned halfword/word or unknown type
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic               we_i,
    input  logic [TYPE_W-1:0]  type_i,
    input  logic [1:0]         addr_i,
    input  logic [REG_LEN-1:0] wdata_i,
    output logic [BE_W-1:0]    be_c_o,
    output logic [REG_LEN-1:0] wdata_c_o,
    output logic               illegal_c_o
);

    always_comb begin
        be_c_o      = '0;
        wdata_c_o   = '0;
        illegal_c_o = 1'b0;
        case (type_i)
            LSU_SB, LSU_SBU: begin
                be_c_o    = BE_W'(4'b0001 << addr_i);
                wdata_c_o = {4{wdata_i[7:0]}};
            end
            LSU_SH, LSU_SHU: begin
                be_c_o      = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c_o   = {2{wdata_i[15:0]}};
                illegal_c_o = addr_i[0];
            end
            LSU_SW: begin
                be_c_o      = 4'b1111;
                wdata_c_o   = wdata_i;
                illegal_c_o = (addr_i != 2'b00);
            end
            default: illegal_c_o = 1'b1;
        endcase
        // Loads keep the byte-enable pattern but never drive write data
        if (!we_i) begin
            wdata_c_o = '0;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between load/store decode and data memory.
// Accepts one request at a time, aligns it to the word, runs a req/ack handshake
// with a bounded wait, and holds sel_type/sel_addr_old for read-data extraction.
//   clk, rst                 clock, synchronous active-high reset
//   lsu_req/we/type/addr/wdata  request from the core (sampled only when idle)
//   lsu_busy/done/err        status back to the core
//   mem_req/we/addr/wdata/be  memory request (held until mem_ack)
//   mem_ack                  memory accept/complete
//   sel_type, sel_addr_old   registered type and byte offset for select_rd
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lsu_req,
    input  logic               lsu_we,
    input  logic [TYPE_W-1:0]  lsu_type,
    input  logic [REG_LEN-1:0] lsu_addr,
    input  logic [REG_LEN-1:0] lsu_wdata,
    output logic               lsu_busy,
    output logic               lsu_done,
    output logic               lsu_err,
    output logic               mem_req,
    output logic               mem_we,
    output logic [REG_LEN-1:0] mem_addr,
    output logic [REG_LEN-1:0] mem_wdata,
    output logic [BE_W-1:0]    mem_be,
    input  logic               mem_ack,
    output logic [TYPE_W-1:0]  sel_type,
    output logic [1:0]         sel_addr_old
);

    localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mac_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mem_cmd_t           cmd_q, cmd_d;
    logic [TYPE_W-1:0]  sel_type_q, sel_type_d;
    logic [1:0]         sel_addr_q, sel_addr_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [BE_W-1:0]    be_c;
    logic [REG_LEN-1:0] wdata_c;
    logic               illegal_c;

    mem_lane_align u_align (
        .we_i        (lsu_we),
        .type_i      (lsu_type),
        .addr_i      (lsu_addr[1:0]),
        .wdata_i     (lsu_wdata),
        .be_c_o      (be_c),
        .wdata_c_o   (wdata_c),
        .illegal_c_o (illegal_c)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MAC_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            sel_type_q <= '0;
            sel_addr_q <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            sel_type_q <= sel_type_d;
            sel_addr_q <= sel_addr_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        sel_type_d = sel_type_q;
        sel_addr_d = sel_addr_q;
        req_d      = req_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            MAC_IDLE: begin
                if (lsu_req) begin
                    if (illegal_c) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_d.we    = lsu_we;
                        cmd_d.addr  = {lsu_addr[REG_LEN-1:2], 2'b00};
                        cmd_d.wdata = wdata_c;
                        cmd_d.be    = be_c;
                        sel_type_d  = lsu_type;
                        sel_addr_d  = lsu_addr[1:0];
                        req_d       = 1'b1;
                        cnt_d       = '0;
                        state_d     = MAC_ACCESS;
                    end
                end
            end
            MAC_ACCESS: begin
                // Ack wins over a timeout landing on the same cycle
                if (mem_ack) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = MAC_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = MAC_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MAC_RESP: begin
                state_d = MAC_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = MAC_IDLE;
            end
        endcase

        busy_d = (state_d != MAC_IDLE);
    end

    assign lsu_busy     = busy_q;
    assign lsu_done     = done_q;
    assign lsu_err      = err_q;
    assign mem_req      = req_q;
    assign mem_we       = cmd_q.we;
    assign mem_addr     = cmd_q.addr;
    assign mem_wdata    = cmd_q.wdata;
    assign mem_be       = cmd_q.be;
    assign sel_type     = sel_type_q;
    assign sel_addr_old = sel_addr_q;

endmodule
